// File: rtl/csr_unit_pkg.sv
// Shared CSR definitions: addresses, op encodings, interrupt causes, bit indices and misa encodings.
// Pure declarations; no latency or backpressure of its own.
package csr_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MISA     = 12'h301;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;

   // Cause codes double as the mie/mip bit positions.
   localparam int IRQ_MSI = 3;
   localparam int IRQ_MTI = 7;
   localparam int IRQ_MEI = 11;

   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   localparam logic [1:0] MISA_MXL_32 = 2'b01;
   localparam logic [1:0] MISA_MXL_64 = 2'b10;
   localparam int         MISA_EXT_I  = 8;

   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
         CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_MHARTID:
            return 1'b1;
         default:
            return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running XLEN-wide counter with a software write that overrides the increment.
// Write or increment lands on the next clk edge; never stalls, wraps from all-ones to 0.
module csr_counter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc_i,
   input  logic            we_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] count_o
);

   localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) begin
         count_o <= '0;
      end else if (we_i) begin
         count_o <= wdata_i;
      end else if (inc_i) begin
         count_o <= count_o + ONE;
      end
   end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with RMW ops, WARL masking, trap/mret sequencing, irq arbitration and counters.
// Reads and irq/trap-vector outputs are combinational, updates land next edge; no backpressure.
module csr_unit
   import csr_unit_pkg::*;
#(
   parameter int              XLEN      = 64,
   parameter logic [XLEN-1:0] HARTID    = '0,
   parameter logic [XLEN-1:0] MTVEC_RST = XLEN'('h100),
   parameter logic [XLEN-1:0] MISA_VAL  =
      {((XLEN == 64) ? MISA_MXL_64 : MISA_MXL_32), {(XLEN-2){1'b0}}} | (XLEN'(1) << MISA_EXT_I)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      csr_op_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_illegal_o,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_tval_i,
   input  logic            mret_i,
   input  logic            retire_i,
   input  logic            ext_irq_i,
   input  logic            sft_irq_i,
   input  logic            tmr_irq_i,
   output logic            irq_req_o,
   output logic [XLEN-1:0] irq_cause_o,
   output logic [XLEN-1:0] trap_vec_o,
   output logic [XLEN-1:0] mepc_o
);

   localparam logic [XLEN-1:0] IRQ_MSB = {1'b1, {(XLEN-1){1'b0}}};

   csr_op_e         op;
   logic            wr_en;
   logic            mstatus_mie, mstatus_mpie;
   logic            mie_mei, mie_msi, mie_mti;
   logic            mip_mei, mip_msi, mip_mti;
   logic            pend_mei, pend_msi, pend_mti;
   logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;
   logic [XLEN-1:0] mstatus_val, mie_val, mip_val, wr_val, tvec_base;

   assign op            = csr_op_e'(csr_op_i);
   assign csr_illegal_o = !csr_implemented(csr_addr_i) ||
                          (op != CSR_NONE && csr_addr_i[11:10] == 2'b11);
   assign wr_en         = (op != CSR_NONE) && !csr_illegal_o && !trap_i && !mret_i;

   always_comb begin
      mstatus_val = '0;
      mstatus_val[MSTATUS_MPP+1:MSTATUS_MPP] = 2'b11;
      mstatus_val[MSTATUS_MIE]  = mstatus_mie;
      mstatus_val[MSTATUS_MPIE] = mstatus_mpie;
      mie_val = '0;
      mie_val[IRQ_MEI] = mie_mei;
      mie_val[IRQ_MTI] = mie_mti;
      mie_val[IRQ_MSI] = mie_msi;
      mip_val = '0;
      mip_val[IRQ_MEI] = mip_mei;
      mip_val[IRQ_MTI] = mip_mti;
      mip_val[IRQ_MSI] = mip_msi;
   end

   always_comb begin
      case (csr_addr_i)
         CSR_MSTATUS:  csr_rdata_o = mstatus_val;
         CSR_MISA:     csr_rdata_o = MISA_VAL;
         CSR_MIE:      csr_rdata_o = mie_val;
         CSR_MTVEC:    csr_rdata_o = mtvec;
         CSR_MSCRATCH: csr_rdata_o = mscratch;
         CSR_MEPC:     csr_rdata_o = mepc;
         CSR_MCAUSE:   csr_rdata_o = mcause;
         CSR_MTVAL:    csr_rdata_o = mtval;
         CSR_MIP:      csr_rdata_o = mip_val;
         CSR_MCYCLE:   csr_rdata_o = mcycle;
         CSR_MINSTRET: csr_rdata_o = minstret;
         CSR_MHARTID:  csr_rdata_o = HARTID;
         default:      csr_rdata_o = '0;
      endcase
   end

   always_comb begin
      case (op)
         CSR_RW:  wr_val = csr_wdata_i;
         CSR_RS:  wr_val = csr_rdata_o | csr_wdata_i;
         CSR_RC:  wr_val = csr_rdata_o & ~csr_wdata_i;
         default: wr_val = csr_rdata_o;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         {mie_mei, mie_mti, mie_msi} <= 3'b000;
         {mip_mei, mip_mti, mip_msi} <= 3'b000;
         mtvec    <= MTVEC_RST;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
         mtval    <= '0;
      end else begin
         {mip_mei, mip_mti, mip_msi} <= {ext_irq_i, tmr_irq_i, sft_irq_i};
         if (trap_i) begin
            mepc         <= {trap_pc_i[XLEN-1:2], 2'b00};
            mcause       <= trap_cause_i;
            mtval        <= trap_tval_i;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (wr_en) begin
            case (csr_addr_i)
               CSR_MSTATUS: begin
                  mstatus_mie  <= wr_val[MSTATUS_MIE];
                  mstatus_mpie <= wr_val[MSTATUS_MPIE];
               end
               CSR_MIE:      {mie_mei, mie_mti, mie_msi} <= {wr_val[IRQ_MEI], wr_val[IRQ_MTI], wr_val[IRQ_MSI]};
               // Reserved mode encodings 2/3 collapse to direct mode.
               CSR_MTVEC:    mtvec    <= {wr_val[XLEN-1:2], wr_val[1] ? 2'b00 : wr_val[1:0]};
               CSR_MSCRATCH: mscratch <= wr_val;
               CSR_MEPC:     mepc     <= {wr_val[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   mcause   <= wr_val;
               CSR_MTVAL:    mtval    <= wr_val;
               default: ;
            endcase
         end
      end
   end

   csr_counter #(.XLEN(XLEN)) u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (1'b1),
      .we_i    (wr_en && csr_addr_i == CSR_MCYCLE),
      .wdata_i (wr_val),
      .count_o (mcycle)
   );

   csr_counter #(.XLEN(XLEN)) u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (retire_i),
      .we_i    (wr_en && csr_addr_i == CSR_MINSTRET),
      .wdata_i (wr_val),
      .count_o (minstret)
   );

   assign pend_mei  = mip_mei & mie_mei;
   assign pend_msi  = mip_msi & mie_msi;
   assign pend_mti  = mip_mti & mie_mti;
   assign irq_req_o = mstatus_mie & (pend_mei | pend_msi | pend_mti);

   always_comb begin
      irq_cause_o = '0;
      if (irq_req_o) begin
         if (pend_mei)      irq_cause_o = IRQ_MSB | XLEN'(IRQ_MEI);
         else if (pend_msi) irq_cause_o = IRQ_MSB | XLEN'(IRQ_MSI);
         else               irq_cause_o = IRQ_MSB | XLEN'(IRQ_MTI);
      end
   end

   // Vectored mode only offsets interrupts; the cause's bit XLEN-2 shifts out of range.
   assign tvec_base  = {mtvec[XLEN-1:2], 2'b00};
   assign trap_vec_o = (mtvec[1:0] == MTVEC_VECTORED && trap_cause_i[XLEN-1]) ?
                       tvec_base + {trap_cause_i[XLEN-3:0], 2'b00} : tvec_base;
   assign mepc_o     = mepc;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (XLEN=64, HARTID=0, MTVEC_RST=0x100).
module tb_csr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [63:0] csr_wdata_i;
   logic [63:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        trap_i;
   logic [63:0] trap_cause_i, trap_pc_i, trap_tval_i;
   logic        mret_i, retire_i;
   logic        ext_irq_i, sft_irq_i, tmr_irq_i;
   logic        irq_req_o;
   logic [63:0] irq_cause_o, trap_vec_o, mepc_o;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [63:0] MSB   = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MISA  = 64'h8000_0000_0000_0100;

   csr_unit #(.XLEN(64), .HARTID(64'h0), .MTVEC_RST(64'h100)) dut (
      .clk           (clk),
      .rst           (rst),
      .csr_op_i      (csr_op_i),
      .csr_addr_i    (csr_addr_i),
      .csr_wdata_i   (csr_wdata_i),
      .csr_rdata_o   (csr_rdata_o),
      .csr_illegal_o (csr_illegal_o),
      .trap_i        (trap_i),
      .trap_cause_i  (trap_cause_i),
      .trap_pc_i     (trap_pc_i),
      .trap_tval_i   (trap_tval_i),
      .mret_i        (mret_i),
      .retire_i      (retire_i),
      .ext_irq_i     (ext_irq_i),
      .sft_irq_i     (sft_irq_i),
      .tmr_irq_i     (tmr_irq_i),
      .irq_req_o     (irq_req_o),
      .irq_cause_o   (irq_cause_o),
      .trap_vec_o    (trap_vec_o),
      .mepc_o        (mepc_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a CSR op and let combinational outputs settle.
   task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] wd);
      csr_op_i    = op;
      csr_addr_i  = addr;
      csr_wdata_i = wd;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
      mret_i = 1'b0; retire_i = 1'b0;
      ext_irq_i = 1'b0; sft_irq_i = 1'b0; tmr_irq_i = 1'b0;
      drive(2'b00, 12'h300, '0);
      step(); step();
      rst = 1'b0;

      // Reset state
      drive(2'b00, 12'h300, '0);
      chk("rst_mstatus", csr_rdata_o, 64'h1800);
      chk("rst_illegal", {63'b0, csr_illegal_o}, 64'd0);
      chk("rst_irq_req", {63'b0, irq_req_o}, 64'd0);
      chk("rst_irq_cause", irq_cause_o, 64'd0);
      chk("rst_mepc", mepc_o, 64'd0);
      drive(2'b00, 12'h305, '0);
      chk("rst_mtvec", csr_rdata_o, 64'h100);

      // RS / RC on mie
      drive(2'b10, 12'h304, 64'h888);
      chk("mie_rs_old", csr_rdata_o, 64'h0);
      step();
      drive(2'b11, 12'h304, 64'h080);
      chk("mie_rc_old", csr_rdata_o, 64'h888);
      step();
      drive(2'b00, 12'h304, '0);
      chk("mie_after_rc", csr_rdata_o, 64'h808);

      // Illegal / read-only accesses
      drive(2'b01, 12'hF14, 64'h5);
      chk("hartid_wr_illegal", {63'b0, csr_illegal_o}, 64'd1);
      step();
      drive(2'b00, 12'h7C0, '0);
      chk("unimpl_rd_illegal", {63'b0, csr_illegal_o}, 64'd1);
      chk("unimpl_rd_data", csr_rdata_o, 64'd0);
      drive(2'b00, 12'hF14, '0);
      chk("hartid_rd_illegal", {63'b0, csr_illegal_o}, 64'd0);
      chk("hartid_rd_data", csr_rdata_o, 64'd0);
      drive(2'b01, 12'h301, 64'h1234);
      chk("misa_wr_legal", {63'b0, csr_illegal_o}, 64'd0);
      step();
      drive(2'b00, 12'h301, '0);
      chk("misa_unchanged", csr_rdata_o, MISA);

      // Interrupt sampling and priority
      drive(2'b01, 12'h304, 64'h888);
      step();
      drive(2'b10, 12'h300, 64'h8);
      step();
      drive(2'b00, 12'h300, '0);
      chk("mstatus_mie_set", csr_rdata_o, 64'h1808);
      ext_irq_i = 1'b1; tmr_irq_i = 1'b1;
      #1;
      chk("irq_latency", {63'b0, irq_req_o}, 64'd0);
      step();
      chk("irq_req_mei", {63'b0, irq_req_o}, 64'd1);
      chk("irq_cause_mei", irq_cause_o, MSB | 64'd11);
      drive(2'b00, 12'h344, '0);
      chk("mip_read", csr_rdata_o, 64'h880);
      ext_irq_i = 1'b0; sft_irq_i = 1'b1;
      step();
      chk("irq_cause_msi", irq_cause_o, MSB | 64'd3);
      sft_irq_i = 1'b0;
      step();
      chk("irq_cause_mti", irq_cause_o, MSB | 64'd7);
      tmr_irq_i = 1'b0;
      step();
      chk("irq_idle_req", {63'b0, irq_req_o}, 64'd0);
      chk("irq_idle_cause", irq_cause_o, 64'd0);

      // mtvec WARL and trap entry with a dropped mscratch write
      drive(2'b01, 12'h305, 64'h2002);
      step();
      drive(2'b00, 12'h305, '0);
      chk("mtvec_mode2", csr_rdata_o, 64'h2000);
      drive(2'b01, 12'h305, 64'h1001);
      step();
      trap_cause_i = 64'd2;
      drive(2'b00, 12'h305, '0);
      chk("mtvec_vec", csr_rdata_o, 64'h1001);
      chk("trap_vec_exc", trap_vec_o, 64'h1000);
      trap_i = 1'b1; trap_cause_i = MSB | 64'd7; trap_pc_i = 64'h2006; trap_tval_i = 64'h55;
      drive(2'b01, 12'h340, 64'hDEAD);
      chk("trap_vec_irq", trap_vec_o, 64'h101C);
      step();
      trap_i = 1'b0;
      drive(2'b00, 12'h340, '0);
      chk("mscratch_dropped", csr_rdata_o, 64'd0);
      chk("trap_mepc", mepc_o, 64'h2004);
      drive(2'b00, 12'h300, '0);
      chk("trap_mstatus", csr_rdata_o, 64'h1880);
      drive(2'b00, 12'h342, '0);
      chk("trap_mcause", csr_rdata_o, MSB | 64'd7);
      drive(2'b00, 12'h343, '0);
      chk("trap_mtval", csr_rdata_o, 64'h55);
      mret_i = 1'b1;
      step();
      mret_i = 1'b0;
      drive(2'b00, 12'h300, '0);
      chk("mret_mstatus", csr_rdata_o, 64'h1888);

      drive(2'b01, 12'h341, 64'h3003);
      step();
      drive(2'b00, 12'h341, '0);
      chk("mepc_warl", csr_rdata_o, 64'h3000);

      // Counters
      drive(2'b01, 12'hB00, ONES);
      step();
      drive(2'b00, 12'hB00, '0);
      chk("mcycle_written", csr_rdata_o, ONES);
      step();
      chk("mcycle_wrap", csr_rdata_o, 64'd0);
      drive(2'b00, 12'hB02, '0);
      chk("minstret_idle", csr_rdata_o, 64'd0);
      retire_i = 1'b1;
      step(); step(); step();
      retire_i = 1'b0;
      #1;
      chk("minstret_count", csr_rdata_o, 64'd3);
      retire_i = 1'b1;
      drive(2'b01, 12'hB02, 64'h10);
      step();
      retire_i = 1'b0;
      drive(2'b00, 12'hB02, '0);
      chk("minstret_wr_over_inc", csr_rdata_o, 64'h10);

      // Reset mid-operation discards the pending write
      drive(2'b01, 12'h340, 64'h77);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(2'b00, 12'h340, '0);
      chk("rst_mid_mscratch", csr_rdata_o, 64'd0);
      chk("rst_mid_mepc", mepc_o, 64'd0);
      drive(2'b00, 12'h300, '0);
      chk("rst_mid_mstatus", csr_rdata_o, 64'h1800);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
